// File: rtl/port_ingress_buffer_if.sv
// Port ingress buffer bus: write-side packet stream in, head-of-line view
// and pop strobe toward the arbiter/selecter, plus the drop counter.
interface port_ingress_buffer_if #(
    parameter int arbiter_data_width = 256
);
    logic                          wr_valid;
    logic                          wr_sop;
    logic                          wr_eop;
    logic [2:0]                    wr_priority;
    logic [arbiter_data_width-1:0] wr_data;
    logic                          wr_ready;
    logic                          rd_en;
    logic                          ready;
    logic                          eop;
    logic [2:0]                    priority_out;
    logic [arbiter_data_width-1:0] data_out;
    logic [7:0]                    drop_cnt;

    // Upstream source plus arbiter side: drives words in and pops the head.
    modport master (
        output wr_valid, wr_sop, wr_eop, wr_priority, wr_data, rd_en,
        input  wr_ready, ready, eop, priority_out, data_out, drop_cnt
    );

    // The buffer itself.
    modport slave (
        input  wr_valid, wr_sop, wr_eop, wr_priority, wr_data, rd_en,
        output wr_ready, ready, eop, priority_out, data_out, drop_cnt
    );
endinterface

// File: rtl/port_ingress_buffer.sv
// Per-port ingress packet buffer. Words are written speculatively and only
// become visible to the read side once the packet's eop word is committed,
// so the arbiter never sees a partial packet. Head word is first-word
// fall-through; one word drains per granted cycle.
module port_ingress_buffer #(
    parameter int arbiter_data_width = 256,
    parameter int data_depth         = 64,
    parameter int desc_depth         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    port_ingress_buffer_if.slave bus
);
    localparam int aw = $clog2(data_depth);
    localparam int dw = $clog2(desc_depth);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    // Storage: each data entry carries its eop flag in the top bit.
    logic [arbiter_data_width:0] mem [data_depth];
    logic [2:0]                  desc_mem [desc_depth];

    // Pointers carry one extra wrap bit so full/empty are unambiguous.
    logic [aw:0] wr_ptr, commit_ptr, rd_ptr;
    logic [aw:0] wr_ptr_nxt, commit_ptr_nxt;
    logic [dw:0] desc_wr_ptr, desc_rd_ptr;
    logic [1:0]  state, state_nxt;
    logic [2:0]  cur_prio;
    logic [7:0]  drop_count;

    logic [aw:0]                 data_used;
    logic [dw:0]                 desc_used;
    logic                        data_full, desc_full;
    logic                        wr_ready_int, accept, overflow;
    logic                        mem_we, desc_push, drop_inc, prio_load;
    logic [aw-1:0]               wr_addr;
    logic [2:0]                  desc_prio;
    logic                        has_pkt, pop, pop_desc;
    logic [arbiter_data_width:0] head;

    // Occupancy: depths are powers of two, so the wrap bit of the
    // difference is set exactly when the FIFO is full.
    always_comb begin
        data_used    = wr_ptr - rd_ptr;
        desc_used    = desc_wr_ptr - desc_rd_ptr;
        data_full    = data_used[aw];
        desc_full    = desc_used[dw];
        // DROP only discards, and the FIFOs are empty there, so it can
        // always take a word.
        wr_ready_int = (state == DROP) || (!data_full && !desc_full);
        accept       = bus.wr_valid && wr_ready_int;
        // A packet that filled the whole FIFO with nothing committed ahead
        // of it can never complete; nothing will ever free space for it.
        overflow     = (state == RECV) && data_full && (commit_ptr == rd_ptr);
    end

    // Write FSM: decides where the accepted word goes, commits, rewinds
    // and counts drops.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_addr        = wr_ptr[aw-1:0];
        mem_we         = 1'b0;
        desc_push      = 1'b0;
        drop_inc       = 1'b0;
        prio_load      = 1'b0;
        case (state)
            IDLE, DROP: begin
                // wr_ptr == commit_ptr here: no partial packet in flight.
                if (accept) begin
                    if (bus.wr_sop) begin
                        mem_we     = 1'b1;
                        prio_load  = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        if (bus.wr_eop) begin
                            commit_ptr_nxt = wr_ptr + 1'b1;
                            desc_push      = 1'b1;
                            state_nxt      = IDLE;
                        end else begin
                            state_nxt = RECV;
                        end
                    end else if (bus.wr_eop) begin
                        // Stray tail in IDLE is a lost packet; in DROP the
                        // packet was already counted at overflow.
                        drop_inc  = (state == IDLE);
                        state_nxt = IDLE;
                    end
                end
            end
            RECV: begin
                if (overflow) begin
                    wr_ptr_nxt = commit_ptr;
                    drop_inc   = 1'b1;
                    state_nxt  = DROP;
                end else if (accept) begin
                    if (bus.wr_sop) begin
                        // Abandon the partial packet and restart at the
                        // commit point in the same cycle.
                        drop_inc   = 1'b1;
                        mem_we     = 1'b1;
                        prio_load  = 1'b1;
                        wr_addr    = commit_ptr[aw-1:0];
                        wr_ptr_nxt = commit_ptr + 1'b1;
                        if (bus.wr_eop) begin
                            commit_ptr_nxt = commit_ptr + 1'b1;
                            desc_push      = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        if (bus.wr_eop) begin
                            commit_ptr_nxt = wr_ptr + 1'b1;
                            desc_push      = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                wr_ptr_nxt = commit_ptr;
            end
        endcase
        // One-word packets commit the priority sampled on that same word.
        desc_prio = bus.wr_sop ? bus.wr_priority : cur_prio;
    end

    // Read side: only committed packets are visible; the head is shown
    // combinationally and gated to zero while nothing is committed.
    always_comb begin
        has_pkt          = (desc_wr_ptr != desc_rd_ptr);
        head             = mem[rd_ptr[aw-1:0]];
        pop              = bus.rd_en && has_pkt;
        pop_desc         = pop && head[arbiter_data_width];
        bus.ready        = has_pkt;
        bus.wr_ready     = wr_ready_int;
        bus.data_out     = has_pkt ? head[arbiter_data_width-1:0] : '0;
        bus.eop          = has_pkt && head[arbiter_data_width];
        bus.priority_out = has_pkt ? desc_mem[desc_rd_ptr[dw-1:0]] : 3'd0;
        bus.drop_cnt     = drop_count;
    end

    // Control state, pointers and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            desc_wr_ptr <= '0;
            desc_rd_ptr <= '0;
            cur_prio    <= 3'd0;
            drop_count  <= 8'd0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            if (prio_load)
                cur_prio <= bus.wr_priority;
            if (desc_push)
                desc_wr_ptr <= desc_wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop_desc)
                desc_rd_ptr <= desc_rd_ptr + 1'b1;
            if (drop_inc && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    // Packet storage; contents are don't-care until committed, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[wr_addr] <= {bus.wr_eop, bus.wr_data};
        if (desc_push && !rst)
            desc_mem[desc_wr_ptr[dw-1:0]] <= desc_prio;
    end
endmodule

// File: tb/tb_port_ingress_buffer.sv
// Directed bench for port_ingress_buffer: one task per scenario, each with
// hand-derived expected values checked inline.
module tb_port_ingress_buffer;
    localparam int W = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    port_ingress_buffer_if #(.arbiter_data_width(W)) bus ();

    port_ingress_buffer #(
        .arbiter_data_width(W),
        .data_depth(64),
        .desc_depth(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] wd(input int tag);
        logic [31:0] t;
        t = tag;
        return {8{t}};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0;
        bus.wr_sop   = 1'b0;
        bus.wr_eop   = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offer one word and hold it until accepted (bounded wait).
    task automatic put_word(input logic sop, input logic eop,
                            input logic [2:0] prio, input logic [W-1:0] d);
        int n;
        bus.wr_valid    = 1'b1;
        bus.wr_sop      = sop;
        bus.wr_eop      = eop;
        bus.wr_priority = prio;
        bus.wr_data     = d;
        n = 0;
        while (!bus.wr_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL put_word_timeout: wr_ready stayed %0b, wanted 1", bus.wr_ready);
        end
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %0b want 1", bus.wr_ready); else passes++;
        checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", bus.ready); else passes++;
        checks++; if (bus.drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); else passes++;
        checks++; if (bus.eop !== 1'b0 || bus.priority_out !== 3'd0 || bus.data_out !== '0)
            $display("FAIL reset_head: eop %0b prio %0d data %0h want 0", bus.eop, bus.priority_out, bus.data_out); else passes++;
        // rd_en on an empty buffer must not move the read pointer.
        bus.rd_en = 1'b1; step(); step(); bus.rd_en = 1'b0;
        put_word(1'b1, 1'b1, 3'd4, wd(32'h0EE0));
        checks++; if (bus.data_out !== wd(32'h0EE0) || bus.priority_out !== 3'd4)
            $display("FAIL empty_pop_ignored: data %0h prio %0d want %0h 4", bus.data_out[31:0], bus.priority_out, 32'h0EE0); else passes++;
    endtask

    task automatic test_basic_packet();
        do_reset();
        put_word(1'b1, 1'b0, 3'd5, wd(32'h100));
        put_word(1'b0, 1'b0, 3'd0, wd(32'h101));
        put_word(1'b0, 1'b0, 3'd0, wd(32'h102));
        checks++; if (bus.ready !== 1'b0) $display("FAIL basic_not_ready_partial: got %0b want 0", bus.ready); else passes++;
        put_word(1'b0, 1'b1, 3'd0, wd(32'h103));
        checks++; if (bus.ready !== 1'b1) $display("FAIL basic_ready: got %0b want 1", bus.ready); else passes++;
        checks++; if (bus.priority_out !== 3'd5) $display("FAIL basic_prio: got %0d want 5", bus.priority_out); else passes++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.data_out !== wd(32'h100 + i))
                $display("FAIL basic_data%0d: got %0h want %0h", i, bus.data_out[31:0], 32'h100 + i); else passes++;
            checks++; if (bus.eop !== (i == 3))
                $display("FAIL basic_eop%0d: got %0b want %0b", i, bus.eop, (i == 3)); else passes++;
            step();
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b0) $display("FAIL basic_ready_after: got %0b want 0", bus.ready); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        put_word(1'b1, 1'b1, 3'd2, wd(32'hA));
        put_word(1'b1, 1'b1, 3'd7, wd(32'hB));
        checks++; if (bus.ready !== 1'b1 || bus.priority_out !== 3'd2 || bus.data_out !== wd(32'hA))
            $display("FAIL b2b_first: ready %0b prio %0d data %0h want 1 2 a", bus.ready, bus.priority_out, bus.data_out[31:0]); else passes++;
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.priority_out !== 3'd7 || bus.data_out !== wd(32'hB))
            $display("FAIL b2b_second: ready %0b prio %0d data %0h want 1 7 b", bus.ready, bus.priority_out, bus.data_out[31:0]); else passes++;
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b0) $display("FAIL b2b_empty: got %0b want 0", bus.ready); else passes++;
    endtask

    task automatic test_sop_abort();
        do_reset();
        put_word(1'b1, 1'b0, 3'd1, wd(32'h10));
        put_word(1'b0, 1'b0, 3'd0, wd(32'h11));
        put_word(1'b0, 1'b0, 3'd0, wd(32'h12));
        put_word(1'b1, 1'b0, 3'd6, wd(32'h20));
        put_word(1'b0, 1'b1, 3'd0, wd(32'h21));
        checks++; if (bus.drop_cnt !== 8'd1) $display("FAIL abort_drop_cnt: got %0d want 1", bus.drop_cnt); else passes++;
        checks++; if (bus.priority_out !== 3'd6 || bus.data_out !== wd(32'h20) || bus.eop !== 1'b0)
            $display("FAIL abort_head: prio %0d data %0h eop %0b want 6 20 0", bus.priority_out, bus.data_out[31:0], bus.eop); else passes++;
        bus.rd_en = 1'b1; step();
        checks++; if (bus.data_out !== wd(32'h21) || bus.eop !== 1'b1)
            $display("FAIL abort_tail: data %0h eop %0b want 21 1", bus.data_out[31:0], bus.eop); else passes++;
        step(); bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b0) $display("FAIL abort_empty: got %0b want 0", bus.ready); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 70; i++)
            put_word(i == 0, i == 69, 3'd3, wd(32'h1000 + i));
        checks++; if (bus.drop_cnt !== 8'd1) $display("FAIL ovf_drop_cnt: got %0d want 1", bus.drop_cnt); else passes++;
        checks++; if (bus.ready !== 1'b0) $display("FAIL ovf_ready: got %0b want 0", bus.ready); else passes++;
        put_word(1'b1, 1'b0, 3'd4, wd(32'h30));
        put_word(1'b0, 1'b1, 3'd0, wd(32'h31));
        checks++; if (bus.ready !== 1'b1 || bus.priority_out !== 3'd4 || bus.data_out !== wd(32'h30))
            $display("FAIL ovf_next_head: ready %0b prio %0d data %0h want 1 4 30", bus.ready, bus.priority_out, bus.data_out[31:0]); else passes++;
        bus.rd_en = 1'b1; step();
        checks++; if (bus.data_out !== wd(32'h31) || bus.eop !== 1'b1)
            $display("FAIL ovf_next_tail: data %0h eop %0b want 31 1", bus.data_out[31:0], bus.eop); else passes++;
        step(); bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b0 || bus.drop_cnt !== 8'd1)
            $display("FAIL ovf_final: ready %0b drop %0d want 0 1", bus.ready, bus.drop_cnt); else passes++;
    endtask

    task automatic test_desc_full();
        do_reset();
        for (int i = 0; i < 16; i++)
            put_word(1'b1, 1'b1, 3'(i % 8), wd(32'h40 + i));
        checks++; if (bus.wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %0b want 0", bus.wr_ready); else passes++;
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        checks++; if (bus.wr_ready !== 1'b1) $display("FAIL full_wr_ready_after_pop: got %0b want 1", bus.wr_ready); else passes++;
        checks++; if (bus.priority_out !== 3'd1 || bus.data_out !== wd(32'h41))
            $display("FAIL full_next_head: prio %0d data %0h want 1 41", bus.priority_out, bus.data_out[31:0]); else passes++;
    endtask

    task automatic test_commit_with_pop();
        do_reset();
        put_word(1'b1, 1'b1, 3'd3, wd(32'h50));
        // Pop the only packet on the same edge a new one commits.
        bus.rd_en = 1'b1;
        put_word(1'b1, 1'b1, 3'd6, wd(32'h51));
        bus.rd_en = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.priority_out !== 3'd6 || bus.data_out !== wd(32'h51))
            $display("FAIL commit_pop: ready %0b prio %0d data %0h want 1 6 51", bus.ready, bus.priority_out, bus.data_out[31:0]); else passes++;
    endtask

    task automatic test_stray_and_saturate();
        do_reset();
        put_word(1'b0, 1'b0, 3'd0, wd(32'h60));
        checks++; if (bus.drop_cnt !== 8'd0) $display("FAIL stray_mid_no_drop: got %0d want 0", bus.drop_cnt); else passes++;
        put_word(1'b0, 1'b1, 3'd0, wd(32'h61));
        checks++; if (bus.drop_cnt !== 8'd1 || bus.ready !== 1'b0)
            $display("FAIL stray_eop_drop: drop %0d ready %0b want 1 0", bus.drop_cnt, bus.ready); else passes++;
        for (int i = 0; i < 258; i++)
            put_word(1'b0, 1'b1, 3'd0, wd(i));
        checks++; if (bus.drop_cnt !== 8'd255) $display("FAIL drop_saturate: got %0d want 255", bus.drop_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        put_word(1'b1, 1'b1, 3'd2, wd(32'h70));
        put_word(1'b1, 1'b0, 3'd2, wd(32'h71));
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (bus.ready !== 1'b0 || bus.wr_ready !== 1'b1 || bus.data_out !== '0)
            $display("FAIL reset_mid: ready %0b wr_ready %0b data %0h want 0 1 0", bus.ready, bus.wr_ready, bus.data_out[31:0]); else passes++;
        put_word(1'b0, 1'b1, 3'd0, wd(32'h72));
        checks++; if (bus.ready !== 1'b0 || bus.drop_cnt !== 8'd1)
            $display("FAIL reset_mid_idle: ready %0b drop %0d want 0 1", bus.ready, bus.drop_cnt); else passes++;
    endtask

    initial begin
        bus.wr_valid    = 1'b0;
        bus.wr_sop      = 1'b0;
        bus.wr_eop      = 1'b0;
        bus.wr_priority = 3'd0;
        bus.wr_data     = '0;
        bus.rd_en       = 1'b0;
        test_reset();
        test_basic_packet();
        test_back_to_back();
        test_sop_abort();
        test_overflow();
        test_desc_full();
        test_commit_with_pop();
        test_stray_and_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
